// File: rtl/mem_pkg.sv
// Shared defaults, FSM encoding and helpers for the March-style memory BIST.
package mem_pkg;

    localparam int DEPTH_DEF  = 256;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 64;
    localparam int ERR_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_R0W1 = 3'd2,
        ST_R1W0 = 3'd3,
        ST_R0   = 3'd4,
        ST_DONE = 3'd5
    } bist_state_e;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter; tc_o flags the last address for the
// current direction (DEPTH-1 counting up, 0 counting down).
module mem_bist_addr_gen #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i)
            cnt_d = up_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = up_i ? (cnt_q == LAST) : (cnt_q == '0);

endmodule

// File: rtl/mem_bist.sv
// March-style memory BIST: W0, R0W1 (up), R1W0 (down), R0 (down) over DEPTH
// words with a latched background pattern; reports pass, first fail address
// and a saturating mismatch count.
module mem_bist
    import mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_w,
    output logic              mem_r,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    bist_state_e       state_q, state_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              wr_half_q, wr_half_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  fail_q, fail_d;
    logic              pass_q, pass_d;

    logic              ld, cnt_en, cnt_up, tc;
    logic [CNT_W-1:0]  ld_val, cnt;
    logic [DATA_W-1:0] wdata, exp_data;

    mem_bist_addr_gen #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ld),
        .load_val_i (ld_val),
        .en_i       (cnt_en),
        .up_i       (cnt_up),
        .cnt_o      (cnt),
        .tc_o       (tc)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        wr_half_d = wr_half_q;
        err_d     = err_q;
        fail_d    = fail_q;
        pass_d    = pass_q;
        ld        = 1'b0;
        ld_val    = '0;
        cnt_en    = 1'b0;
        cnt_up    = 1'b1;
        mem_w     = 1'b0;
        mem_r     = 1'b0;
        wdata     = '0;
        exp_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_W0;
                    pat_d     = pattern;
                    err_d     = '0;
                    fail_d    = '0;
                    pass_d    = 1'b0;
                    wr_half_d = 1'b0;
                    ld        = 1'b1;
                end
            end
            ST_W0: begin
                busy   = 1'b1;
                mem_w  = 1'b1;
                wdata  = pat_q;
                cnt_en = 1'b1;
                if (tc) begin
                    state_d = ST_R0W1;
                    ld      = 1'b1;
                end
            end
            ST_R0W1: begin
                busy = 1'b1;
                if (!wr_half_q) begin
                    mem_r     = 1'b1;
                    exp_data  = pat_q;
                    wr_half_d = 1'b1;
                end else begin
                    mem_w     = 1'b1;
                    wdata     = ~pat_q;
                    wr_half_d = 1'b0;
                    cnt_en    = 1'b1;
                    if (tc) begin
                        state_d = ST_R1W0;
                        ld      = 1'b1;
                        ld_val  = LAST;
                    end
                end
            end
            ST_R1W0: begin
                busy   = 1'b1;
                cnt_up = 1'b0;
                if (!wr_half_q) begin
                    mem_r     = 1'b1;
                    exp_data  = ~pat_q;
                    wr_half_d = 1'b1;
                end else begin
                    mem_w     = 1'b1;
                    wdata     = pat_q;
                    wr_half_d = 1'b0;
                    cnt_en    = 1'b1;
                    if (tc) begin
                        state_d = ST_R0;
                        ld      = 1'b1;
                        ld_val  = LAST;
                    end
                end
            end
            ST_R0: begin
                busy     = 1'b1;
                cnt_up   = 1'b0;
                mem_r    = 1'b1;
                exp_data = pat_q;
                // Hold at address 0 rather than wrapping into DONE.
                cnt_en   = !tc;
                if (tc)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Compare lands on the edge that closes the read cycle.
        if (mem_r && (mem_dataout != exp_data)) begin
            err_d = sat_inc(err_q);
            if (err_q == '0)
                fail_d = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            wr_half_q <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            wr_half_q <= wr_half_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            pass_q    <= pass_d;
        end
    end

    assign mem_adr    = ADDR_W'(cnt);
    assign mem_datain = wdata;
    assign pass       = pass_q;
    assign fail_adr   = ADDR_W'(fail_q);
    assign err_count  = err_q;

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, giving the number of memory words tested.
REQ-002 The module SHALL have parameter DATA_W, default 64, giving the memory data width.
REQ-003 The module SHALL have parameter ADDR_W, default 64, giving the memory address bus width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a test run.
REQ-007 pattern  input  DATA_W  background test word, sampled when start is accepted.
REQ-008 mem_adr  output  ADDR_W  address to memory.
REQ-009 mem_datain  output  DATA_W  write data to memory.
REQ-010 mem_w  output  1  memory write enable; the memory writes on the next rising edge.
REQ-011 mem_r  output  1  memory read enable.
REQ-012 mem_dataout  input  DATA_W  combinational memory read data; valid only while mem_r=1.
REQ-013 busy  output  1  high from the cycle after start is accepted until the run completes.
REQ-014 done  output  1  one-cycle pulse at run end.
REQ-015 pass  output  1  high when the last completed run had zero mismatches.
REQ-016 fail_adr  output  ADDR_W  address of the first mismatch in the last run.
REQ-017 err_count  output  10  mismatch count of the last run, saturating at 1023.

Function
REQ-018 The FSM SHALL have states IDLE, W0, R0W1, R1W0, R0, DONE.
REQ-019 In IDLE, start=1 SHALL latch pattern as P, clear err_count, fail_adr and pass, and move to W0 on the next edge; start SHALL be ignored in every other state.
REQ-020 W0 SHALL take DEPTH cycles, ascending addresses 0..DEPTH-1, one write of P per cycle (mem_w=1, mem_r=0).
REQ-021 R0W1 SHALL visit addresses ascending, two cycles each: a read cycle (mem_r=1) expecting P, then a write cycle writing ~P; 2*DEPTH cycles in total.
REQ-022 R1W0 SHALL visit addresses descending DEPTH-1..0, two cycles each: a read expecting ~P, then a write of P; 2*DEPTH cycles in total.
REQ-023 R0 SHALL visit addresses descending, one read per cycle expecting P; DEPTH cycles in total.
REQ-024 A read compare SHALL sample mem_dataout at the rising edge that ends the read cycle; a mismatch is any bit difference.
REQ-025 On a mismatch, err_count SHALL increment (saturating at 1023); fail_adr SHALL be loaded only on the first mismatch of the run.
REQ-026 mem_w and mem_r SHALL never both be 1, and both SHALL be 0 in IDLE and DONE.
REQ-027 mem_adr[ADDR_W-1:8] SHALL be 0 throughout, i.e. the address is zero-extended from the internal counter.
REQ-028 Phase transitions SHALL occur on the edge after the last address of a phase, with no idle cycle in between.
REQ-029 DONE SHALL last exactly one cycle with done=1, set pass=(err_count==0), then return to IDLE.
REQ-030 Run latency from the start-accept edge to done=1 SHALL be 6*DEPTH+1 cycles (1537 at the default DEPTH).
REQ-031 pass, fail_adr and err_count SHALL hold their values until the next accepted start.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, with mem_w=0, mem_r=0, mem_adr=0, mem_datain=0, busy=0, done=0, pass=0, fail_adr=0, err_count=0.
REQ-033 A reset asserted mid-run SHALL abort the run with no partial result retained; after release the block SHALL wait in IDLE for start.

Structure
REQ-034 DEPTH, DATA_W, ADDR_W defaults and the FSM state encoding SHALL live in shared package mem_pkg.
REQ-035 Addressing SHALL be implemented in sub-module mem_bist_addr_gen: a loadable up/down counter with a terminal-count flag.

Verification
REQ-036 Fault-free memory, pattern=64'hA5A5A5A5A5A5A5A5, start pulse -> busy=1 on the next cycle; done after 1537 cycles; pass=1, err_count=0.
REQ-037 Memory with address 8'h2A bit 0 stuck at 1, pattern=0 -> pass=0, fail_adr=64'h2A, err_count=2 (one mismatch in R0W1, one in R0).
REQ-038 start re-pulsed 100 cycles into a run -> no restart; done still 1537 cycles after the first start.
REQ-039 rst_n pulsed low during R1W0 -> all outputs reset in the same cycle, no further mem_w; start after release gives a full clean run with pass=1.
REQ-040 Address trace monitor -> W0 and R0W1 run 0..255, R1W0 and R0 run 255..0; mem_adr[63:8]=0 and mem_w&mem_r=0 on every cycle.
